// File: rtl/adder_chk_pkg.sv
// Shared types and defaults for the adder response checker.
// State encoding is fixed so it can be probed from waveforms.
package adder_chk_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/chk_fifo.sv
// Synchronous FIFO holding expected results for the checker.
// Pointers carry one extra wrap bit for full/empty detection.
module chk_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/adder_resp_checker.sv
// Response checker: queues expected adder results and
// compares them with the adder outputs as they arrive.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             finish,
  input  logic             stim_valid,
  input  logic [WIDTH-1:0] stim_a,
  input  logic [WIDTH-1:0] stim_b,
  input  logic             stim_cin,
  input  logic             resp_valid,
  input  logic [WIDTH-1:0] resp_sum,
  input  logic             resp_cout,
  output logic             stim_ready,
  output logic             mismatch,
  output logic [WIDTH:0]   exp_out,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             ovf,
  output logic             unf,
  output logic             done
);

  state_t state, state_n;

  logic           full, empty;
  logic           active, push, pop;
  logic           ovf_set, unf_set;
  logic [WIDTH:0] exp_in, head, got;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v
  );
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign exp_in = {1'b0, stim_a} + {1'b0, stim_b} +
                  {{WIDTH{1'b0}}, stim_cin};
  assign got    = {resp_cout, resp_sum};

  assign active  = (state == RUN) || (state == DRAIN);
  assign pop     = !start && active && resp_valid && !empty;
  assign unf_set = !start && active && resp_valid && empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts
  assign push    = !start && (state == RUN) && stim_valid &&
                   (!full || pop);
  assign ovf_set = !start && (state == RUN) && stim_valid &&
                   full && !pop;

  assign stim_ready = (state == RUN) && !full;
  assign done       = (state == DONE);

  chk_fifo #(
    .DW   (WIDTH + 1),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .push (push),
    .pop  (pop),
    .din  (exp_in),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (start) begin
      state_n = RUN;
    end else begin
      case (state)
        RUN:     if (finish) state_n = DRAIN;
        DRAIN:   if (empty)  state_n = DONE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      mismatch <= 1'b0;
      exp_out  <= '0;
      pass_cnt <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
      unf      <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      if (ovf_set) ovf <= 1'b1;
      if (unf_set) begin
        unf     <= 1'b1;
        err_cnt <= sat_inc(err_cnt);
      end
      if (pop) begin
        exp_out <= head;
        if (head == got) begin
          pass_cnt <= sat_inc(pass_cnt);
        end else begin
          err_cnt  <= sat_inc(err_cnt);
          mismatch <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker.
// Each task drives one scenario and checks inline.
module tb_adder_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, finish;
  logic       stim_valid, stim_cin;
  logic [3:0] stim_a, stim_b;
  logic       resp_valid, resp_cout;
  logic [3:0] resp_sum;
  logic       stim_ready, mismatch, ovf, unf, done;
  logic [4:0] exp_out;
  logic [15:0] pass_cnt, err_cnt;

  int errors = 0;
  int checks = 0;

  logic [3:0] ta  [8] = '{4'hF, 4'hE, 4'h9, 4'h0, 4'h8, 4'h7, 4'h3, 4'hA};
  logic [3:0] tb  [8] = '{4'hF, 4'h1, 4'h9, 4'h0, 4'h8, 4'h2, 4'hC, 4'h5};
  logic       tc  [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [4:0] tex [8] = '{5'h1F, 5'h10, 5'h12, 5'h01,
                          5'h10, 5'h0A, 5'h10, 5'h0F};

  adder_resp_checker dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .finish    (finish),
    .stim_valid(stim_valid),
    .stim_a    (stim_a),
    .stim_b    (stim_b),
    .stim_cin  (stim_cin),
    .resp_valid(resp_valid),
    .resp_sum  (resp_sum),
    .resp_cout (resp_cout),
    .stim_ready(stim_ready),
    .mismatch  (mismatch),
    .exp_out   (exp_out),
    .pass_cnt  (pass_cnt),
    .err_cnt   (err_cnt),
    .ovf       (ovf),
    .unf       (unf),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_push(input logic [3:0] a, input logic [3:0] b,
                         input logic c);
    stim_valid = 1'b1;
    stim_a = a;
    stim_b = b;
    stim_cin = c;
    tick();
    stim_valid = 1'b0;
  endtask

  task automatic do_resp(input logic [4:0] v);
    resp_valid = 1'b1;
    {resp_cout, resp_sum} = v;
    tick();
    resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({stim_ready, mismatch, ovf, unf, done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 00000",
               {stim_ready, mismatch, ovf, unf, done});
    end
    checks++;
    if ({exp_out, pass_cnt, err_cnt} !== 37'b0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h want 0/0/0",
               exp_out, pass_cnt, err_cnt);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pass();
    do_start();
    checks++;
    if (stim_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_ready: got %b want 1", stim_ready);
    end
    do_push(4'hF, 4'h1, 1'b0);
    do_resp(5'h10);
    checks++;
    if (exp_out !== 5'h10 || pass_cnt !== 16'd1 || mismatch !== 1'b0) begin
      errors++;
      $display("FAIL pass_one: got exp=%h pass=%0d mm=%b want 10/1/0",
               exp_out, pass_cnt, mismatch);
    end
  endtask

  task automatic test_mismatch();
    do_start();
    do_push(4'h3, 4'h4, 1'b0);
    do_resp(5'h08);
    checks++;
    if (mismatch !== 1'b1 || exp_out !== 5'h07 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL mm_pulse: got mm=%b exp=%h err=%0d want 1/07/1",
               mismatch, exp_out, err_cnt);
    end
    tick();
    checks++;
    if (mismatch !== 1'b0 || pass_cnt !== 16'd0) begin
      errors++;
      $display("FAIL mm_width: got mm=%b pass=%0d want 0/0",
               mismatch, pass_cnt);
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (stim_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready%0d: got %b want 1", i, stim_ready);
      end
      do_push(ta[i], tb[i], tc[i]);
    end
    checks++;
    if (stim_ready !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: got rdy=%b ovf=%b want 0/0",
               stim_ready, ovf);
    end
    do_push(4'h1, 4'h1, 1'b0);
    checks++;
    if (ovf !== 1'b1 || stim_ready !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set: got ovf=%b rdy=%b want 1/0", ovf, stim_ready);
    end
    for (int i = 0; i < 8; i++) begin
      do_resp(tex[i]);
      checks++;
      if (exp_out !== tex[i] || mismatch !== 1'b0) begin
        errors++;
        $display("FAIL drain%0d: got exp=%h mm=%b want %h/0",
                 i, exp_out, mismatch, tex[i]);
      end
    end
    checks++;
    if (pass_cnt !== 16'd8 || err_cnt !== 16'd0 || stim_ready !== 1'b1) begin
      errors++;
      $display("FAIL ovf_totals: got pass=%0d err=%0d rdy=%b want 8/0/1",
               pass_cnt, err_cnt, stim_ready);
    end
  endtask

  task automatic test_underflow();
    do_start();
    do_resp(5'h00);
    checks++;
    if (unf !== 1'b1 || err_cnt !== 16'd1 || pass_cnt !== 16'd0 ||
        mismatch !== 1'b0) begin
      errors++;
      $display("FAIL unf: got unf=%b err=%0d pass=%0d mm=%b want 1/1/0/0",
               unf, err_cnt, pass_cnt, mismatch);
    end
    for (int i = 0; i < 8; i++) do_push(ta[i], tb[i], tc[i]);
    stim_valid = 1'b1;
    stim_a = 4'h6;
    stim_b = 4'h6;
    stim_cin = 1'b1;
    resp_valid = 1'b1;
    {resp_cout, resp_sum} = tex[0];
    tick();
    stim_valid = 1'b0;
    resp_valid = 1'b0;
    checks++;
    if (ovf !== 1'b0 || pass_cnt !== 16'd1 || stim_ready !== 1'b0) begin
      errors++;
      $display("FAIL pushpop_full: got ovf=%b pass=%0d rdy=%b want 0/1/0",
               ovf, pass_cnt, stim_ready);
    end
    for (int i = 1; i < 8; i++) do_resp(tex[i]);
    do_resp(5'h0D);
    checks++;
    if (exp_out !== 5'h0D || pass_cnt !== 16'd9 || err_cnt !== 16'd1) begin
      errors++;
      $display("FAIL pushpop_tail: got exp=%h pass=%0d err=%0d want 0D/9/1",
               exp_out, pass_cnt, err_cnt);
    end
  endtask

  task automatic test_drain();
    do_start();
    for (int i = 0; i < 3; i++) do_push(ta[i], tb[i], tc[i]);
    finish = 1'b1;
    tick();
    finish = 1'b0;
    checks++;
    if (done !== 1'b0 || stim_ready !== 1'b0) begin
      errors++;
      $display("FAIL drain_enter: got done=%b rdy=%b want 0/0",
               done, stim_ready);
    end
    do_push(4'h1, 4'h2, 1'b0);
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL drain_stim: got ovf=%b want 0", ovf);
    end
    for (int i = 0; i < 3; i++) do_resp(tex[i]);
    checks++;
    if (done !== 1'b0 || exp_out !== tex[2]) begin
      errors++;
      $display("FAIL drain_last: got done=%b exp=%h want 0/%h",
               done, exp_out, tex[2]);
    end
    tick();
    checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd3 || err_cnt !== 16'd0) begin
      errors++;
      $display("FAIL done: got done=%b pass=%0d err=%0d want 1/3/0",
               done, pass_cnt, err_cnt);
    end
    tick();
    tick();
    checks++;
    if (done !== 1'b1 || pass_cnt !== 16'd3) begin
      errors++;
      $display("FAIL done_hold: got done=%b pass=%0d want 1/3",
               done, pass_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_start();
    for (int i = 0; i < 4; i++) do_push(ta[i], tb[i], tc[i]);
    rst_n = 1'b0;
    tick();
    checks++;
    if ({stim_ready, mismatch, ovf, unf, done} !== 5'b0 ||
        {exp_out, pass_cnt, err_cnt} !== 37'b0) begin
      errors++;
      $display("FAIL rst_mid: got %b %h/%h/%h want all 0",
               {stim_ready, mismatch, ovf, unf, done},
               exp_out, pass_cnt, err_cnt);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_resp(tex[i]);
    checks++;
    if (pass_cnt !== 16'd0 || err_cnt !== 16'd0 || unf !== 1'b0 ||
        mismatch !== 1'b0) begin
      errors++;
      $display("FAIL idle_resp: got pass=%0d err=%0d unf=%b mm=%b want 0",
               pass_cnt, err_cnt, unf, mismatch);
    end
    do_start();
    do_resp(tex[0]);
    checks++;
    if (unf !== 1'b1 || err_cnt !== 16'd1 || pass_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rst_flush: got unf=%b err=%0d pass=%0d want 1/1/0",
               unf, err_cnt, pass_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    finish = 1'b0;
    stim_valid = 1'b0;
    stim_a = '0;
    stim_b = '0;
    stim_cin = 1'b0;
    resp_valid = 1'b0;
    resp_sum = '0;
    resp_cout = 1'b0;
    test_reset();
    test_pass();
    test_mismatch();
    test_overflow();
    test_underflow();
    test_drain();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
